// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives data memory over a req/ack handshake
// and registers the bundle handed to MEM/WB.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ValidIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        MemToRegIn,
  input  logic        RegWriteIn,
  input  logic [31:0] WriteRegisterIn,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] WriteDataIn,
  input  logic [31:0] InstructionIn,
  output logic        Stall,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        MEM_WB_Signal,
  output logic [31:0] InstructionOut,
  output logic        MemToRegOut,
  output logic        RegWriteOut,
  output logic [31:0] WriteRegisterOut,
  output logic [31:0] ALUResultOut,
  output logic [31:0] DataMemoryOut,
  output logic        AlignError,
  output logic        BusError
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        mem_to_reg;
    logic        reg_write;
    logic [31:0] wreg;
  } ctl_t;

  typedef struct packed {
    ctl_t        ctl;
    logic [31:0] alu;
    logic [31:0] data;
  } wb_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic        req, req_nx;
  logic        we, we_nx;
  logic [31:2] addr, addr_nx;
  logic [31:0] wdata, wdata_nx;
  ctl_t        held, held_nx;
  wb_t         wb, wb_nx;
  logic        bubble, bubble_nx;
  logic        align, align_nx;
  logic        bus, bus_nx;

  logic memop, mis, go, pass, expired;
  ctl_t ctl_in;

  assign memop   = ValidIn & (MemReadIn | MemWriteIn);
  assign mis     = memop & (ALUResultIn[1:0] != 2'b00);
  assign go      = memop & ~mis;
  assign pass    = ValidIn & ~memop;
  assign expired = ~MemAck & (cnt == LAST);

  assign ctl_in = '{
    instr:      InstructionIn,
    mem_to_reg: MemToRegIn,
    reg_write:  RegWriteIn,
    wreg:       WriteRegisterIn
  };

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    req_nx    = req;
    we_nx     = we;
    addr_nx   = addr;
    wdata_nx  = wdata;
    held_nx   = held;
    wb_nx     = '0;
    bubble_nx = 1'b1;
    align_nx  = 1'b0;
    bus_nx    = bus;
    Stall     = 1'b0;
    unique case (state)
      S_IDLE: begin
        unique case (1'b1)
          mis: align_nx = 1'b1;
          go: begin
            Stall    = 1'b1;
            state_nx = S_WAIT;
            cnt_nx   = '0;
            req_nx   = 1'b1;
            we_nx    = MemWriteIn;
            addr_nx  = ALUResultIn[31:2];
            wdata_nx = WriteDataIn;
            held_nx  = ctl_in;
          end
          pass: begin
            wb_nx.ctl = ctl_in;
            wb_nx.alu = ALUResultIn;
            bubble_nx = 1'b0;
          end
          default: ;
        endcase
      end
      S_WAIT: begin
        // A timeout releases upstream so the dropped op is not retried
        Stall = ~MemAck & ~expired;
        unique case (1'b1)
          MemAck: begin
            state_nx   = S_IDLE;
            req_nx     = 1'b0;
            wb_nx.ctl  = held;
            wb_nx.alu  = {addr, 2'b00};
            wb_nx.data = we ? 32'd0 : MemRData;
            bubble_nx  = 1'b0;
          end
          expired: begin
            state_nx = S_IDLE;
            req_nx   = 1'b0;
            bus_nx   = 1'b1;
          end
          default: cnt_nx = cnt + CNT_W'(1);
        endcase
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      req    <= 1'b0;
      we     <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      held   <= '0;
      wb     <= '0;
      bubble <= 1'b1;
      align  <= 1'b0;
      bus    <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      req    <= req_nx;
      we     <= we_nx;
      addr   <= addr_nx;
      wdata  <= wdata_nx;
      held   <= held_nx;
      wb     <= wb_nx;
      bubble <= bubble_nx;
      align  <= align_nx;
      bus    <= bus_nx;
    end
  end

  assign MemReq           = req;
  assign MemWe            = we;
  assign MemAddr          = {addr, 2'b00};
  assign MemWData         = wdata;
  assign MEM_WB_Signal    = bubble;
  assign InstructionOut   = wb.ctl.instr;
  assign MemToRegOut      = wb.ctl.mem_to_reg;
  assign RegWriteOut      = wb.ctl.reg_write;
  assign WriteRegisterOut = wb.ctl.wreg;
  assign ALUResultOut     = wb.alu;
  assign DataMemoryOut    = wb.data;
  assign AlignError       = align;
  assign BusError         = bus;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a scoreboard
// of expected MEM/WB bundles.
module tb_mem_access_stage;

  logic        Clock;
  logic        Reset;
  logic        ValidIn, MemReadIn, MemWriteIn;
  logic        MemToRegIn, RegWriteIn;
  logic [31:0] WriteRegisterIn, ALUResultIn;
  logic [31:0] WriteDataIn, InstructionIn;
  logic        Stall, MemReq, MemWe;
  logic [31:0] MemAddr, MemWData;
  logic        MemAck;
  logic [31:0] MemRData;
  logic        MEM_WB_Signal;
  logic [31:0] InstructionOut;
  logic        MemToRegOut, RegWriteOut;
  logic [31:0] WriteRegisterOut, ALUResultOut;
  logic [31:0] DataMemoryOut;
  logic        AlignError, BusError;

  typedef struct packed {
    logic [31:0] instr;
    logic        mtr;
    logic        rw;
    logic [31:0] wreg;
    logic [31:0] alu;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int passed = 0;
  int total  = 0;

  mem_access_stage #(
    .TIMEOUT_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .ValidIn(ValidIn),
    .MemReadIn(MemReadIn),
    .MemWriteIn(MemWriteIn),
    .MemToRegIn(MemToRegIn),
    .RegWriteIn(RegWriteIn),
    .WriteRegisterIn(WriteRegisterIn),
    .ALUResultIn(ALUResultIn),
    .WriteDataIn(WriteDataIn),
    .InstructionIn(InstructionIn),
    .Stall(Stall),
    .MemReq(MemReq),
    .MemWe(MemWe),
    .MemAddr(MemAddr),
    .MemWData(MemWData),
    .MemAck(MemAck),
    .MemRData(MemRData),
    .MEM_WB_Signal(MEM_WB_Signal),
    .InstructionOut(InstructionOut),
    .MemToRegOut(MemToRegOut),
    .RegWriteOut(RegWriteOut),
    .WriteRegisterOut(WriteRegisterOut),
    .ALUResultOut(ALUResultOut),
    .DataMemoryOut(DataMemoryOut),
    .AlignError(AlignError),
    .BusError(BusError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic v, rd, wr, mtr, rw,
                       input logic [31:0] wreg, alu, wd, ins);
    ValidIn         = v;
    MemReadIn       = rd;
    MemWriteIn      = wr;
    MemToRegIn      = mtr;
    RegWriteIn      = rw;
    WriteRegisterIn = wreg;
    ALUResultIn     = alu;
    WriteDataIn     = wd;
    InstructionIn   = ins;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Scoreboard: every non-bubble MEM/WB bundle must match the queue head
  exp_t e;
  always @(negedge Clock) begin
    if (!Reset && MEM_WB_Signal === 1'b0) begin
      if (q.size() == 0) begin
        check("unexpected_out", 32'(q.size() > 0), 1);
      end else begin
        e = q.pop_front();
        check("sb_instr", InstructionOut, e.instr);
        check("sb_memtoreg", 32'(MemToRegOut), 32'(e.mtr));
        check("sb_regwrite", 32'(RegWriteOut), 32'(e.rw));
        check("sb_wreg", WriteRegisterOut, e.wreg);
        check("sb_alu", ALUResultOut, e.alu);
        check("sb_data", DataMemoryOut, e.data);
      end
    end
  end

  initial begin
    Reset = 1'b1;
    idle();
    MemAck   = 1'b0;
    MemRData = 32'd0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    check("rst_bubble", 32'(MEM_WB_Signal), 1);
    check("rst_instr", InstructionOut, 0);
    check("rst_alu", ALUResultOut, 0);
    check("rst_wreg", WriteRegisterOut, 0);
    check("rst_data", DataMemoryOut, 0);
    check("rst_rw", 32'(RegWriteOut), 0);
    check("rst_mtr", 32'(MemToRegOut), 0);
    check("rst_req", 32'(MemReq), 0);
    check("rst_stall", 32'(Stall), 0);
    check("rst_bus", 32'(BusError), 0);
    check("rst_align", 32'(AlignError), 0);

    // ADD pass-through
    tick();
    drive(1, 0, 0, 0, 1, 5, 32'h1234, 0, 32'h0062_82b3);
    q.push_back('{32'h0062_82b3, 0, 1, 5, 32'h1234, 0});
    @(negedge Clock);
    check("add_stall", 32'(Stall), 0);
    tick();
    idle();
    @(negedge Clock);
    check("add_bubble", 32'(MEM_WB_Signal), 0);

    // LW 0x40, ack on 4th WAIT cycle (also the timeout cycle)
    tick();
    drive(1, 1, 0, 1, 1, 7, 32'h40, 0, 32'h0400_2383);
    q.push_back('{32'h0400_2383, 1, 1, 7, 32'h40,
                  32'hDEAD_BEEF});
    @(negedge Clock);
    check("lw_stall0", 32'(Stall), 1);
    check("lw_req0", 32'(MemReq), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge Clock);
      check("lw_stall", 32'(Stall), 1);
      check("lw_req", 32'(MemReq), 1);
      check("lw_addr", MemAddr, 32'h40);
      check("lw_we", 32'(MemWe), 0);
      check("lw_bubble", 32'(MEM_WB_Signal), 1);
    end
    tick();
    MemAck   = 1'b1;
    MemRData = 32'hDEAD_BEEF;
    @(negedge Clock);
    check("lw_ack_stall", 32'(Stall), 0);
    check("lw_ack_addr", MemAddr, 32'h40);
    check("lw_ack_req", 32'(MemReq), 1);
    tick();
    MemAck   = 1'b0;
    MemRData = 32'd0;
    idle();
    @(negedge Clock);
    check("lw_req_drop", 32'(MemReq), 0);
    check("lw_bus", 32'(BusError), 0);

    // SW 0x44, ack first WAIT cycle, then back-to-back ADDs
    tick();
    drive(1, 0, 1, 0, 0, 0, 32'h44, 32'hA5A5_A5A5,
          32'h0450_2223);
    q.push_back('{32'h0450_2223, 0, 0, 0, 32'h44, 0});
    @(negedge Clock);
    check("sw_stall0", 32'(Stall), 1);
    tick();
    MemAck   = 1'b1;
    MemRData = 32'h1234_5678;
    @(negedge Clock);
    check("sw_req", 32'(MemReq), 1);
    check("sw_we", 32'(MemWe), 1);
    check("sw_wdata", MemWData, 32'hA5A5_A5A5);
    check("sw_addr", MemAddr, 32'h44);
    check("sw_stall", 32'(Stall), 0);
    tick();
    MemAck   = 1'b0;
    MemRData = 32'd0;
    drive(1, 0, 0, 0, 1, 9, 32'h99, 0, 32'h0011_04b3);
    q.push_back('{32'h0011_04b3, 0, 1, 9, 32'h99, 0});
    @(negedge Clock);
    check("sw_out_bubble", 32'(MEM_WB_Signal), 0);
    check("add2_stall", 32'(Stall), 0);
    tick();
    drive(1, 0, 0, 0, 1, 10, 32'hAB, 0, 32'h0022_0533);
    q.push_back('{32'h0022_0533, 0, 1, 10, 32'hAB, 0});
    @(negedge Clock);
    check("add2_bubble", 32'(MEM_WB_Signal), 0);
    check("add3_stall", 32'(Stall), 0);
    tick();
    idle();
    @(negedge Clock);
    check("add3_bubble", 32'(MEM_WB_Signal), 0);
    tick();
    @(negedge Clock);
    check("idle_bubble", 32'(MEM_WB_Signal), 1);

    // Misaligned LW 0x42
    tick();
    drive(1, 1, 0, 1, 1, 3, 32'h42, 0, 32'h0420_2183);
    @(negedge Clock);
    check("mis_stall", 32'(Stall), 0);
    check("mis_req0", 32'(MemReq), 0);
    check("mis_align0", 32'(AlignError), 0);
    tick();
    idle();
    @(negedge Clock);
    check("mis_align", 32'(AlignError), 1);
    check("mis_req1", 32'(MemReq), 0);
    check("mis_bubble", 32'(MEM_WB_Signal), 1);
    tick();
    @(negedge Clock);
    check("mis_align_clr", 32'(AlignError), 0);
    check("mis_req2", 32'(MemReq), 0);

    // LW with no ack -> timeout after 4 WAIT cycles
    tick();
    drive(1, 1, 0, 1, 1, 8, 32'h80, 0, 32'h0800_2403);
    @(negedge Clock);
    check("to_stall0", 32'(Stall), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge Clock);
      check("to_req", 32'(MemReq), 1);
      check("to_stall", 32'(Stall), 32'(i < 3));
      check("to_bus_pre", 32'(BusError), 0);
    end
    tick();
    idle();
    @(negedge Clock);
    check("to_req_drop", 32'(MemReq), 0);
    check("to_bus", 32'(BusError), 1);
    check("to_bubble", 32'(MEM_WB_Signal), 1);
    tick();
    MemAck = 1'b1;
    @(negedge Clock);
    check("stray_ack_stall", 32'(Stall), 0);
    check("stray_ack_req", 32'(MemReq), 0);
    tick();
    MemAck = 1'b0;
    @(negedge Clock);
    check("bus_sticky", 32'(BusError), 1);
    check("stray_ack_bubble", 32'(MEM_WB_Signal), 1);

    // Reset during WAIT
    tick();
    drive(1, 1, 0, 1, 1, 4, 32'h100, 0, 32'h1000_2203);
    @(negedge Clock);
    check("rw_stall0", 32'(Stall), 1);
    tick();
    @(negedge Clock);
    check("rw_req", 32'(MemReq), 1);
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    idle();
    @(negedge Clock);
    check("rw_req_drop", 32'(MemReq), 0);
    check("rw_bus_clr", 32'(BusError), 0);
    check("rw_bubble", 32'(MEM_WB_Signal), 1);
    check("rw_stall", 32'(Stall), 0);

    // Stage still works after reset
    tick();
    drive(1, 0, 0, 0, 1, 11, 32'h5555, 0, 32'h0033_05b3);
    q.push_back('{32'h0033_05b3, 0, 1, 11, 32'h5555, 0});
    tick();
    idle();
    @(negedge Clock);
    tick();
    @(negedge Clock);
    check("queue_drained", 32'(q.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage: takes the EX/MEM bundle, performs the load/store on the data memory over a req/ack handshake, and produces the registered bundle consumed by MEM_WB_Register.
- Supports variable-latency memory: stalls upstream while an access is outstanding and presents a bubble to MEM/WB through MEM_WB_Signal.
- Adds word-alignment checking and an access timeout.

Parameters:
- TIMEOUT_CYCLES, 16: maximum WAIT cycles before an access is abandoned (≥1).
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- ValidIn  in  1  EX/MEM bundle holds a real instruction
- MemReadIn  in  1  load
- MemWriteIn  in  1  store
- MemToRegIn  in  1  writeback selects memory data
- RegWriteIn  in  1  writeback enable
- WriteRegisterIn  in  32  destination register
- ALUResultIn  in  32  effective address / ALU result
- WriteDataIn  in  32  store data
- InstructionIn  in  32  instruction word
- Stall  out  1  combinational; upstream holds its bundle while 1
- MemReq  out  1  memory request
- MemWe  out  1  1 = write
- MemAddr  out  32  word-aligned address
- MemWData  out  32  store data
- MemAck  in  1  request completes this cycle
- MemRData  in  32  load data, valid with MemAck
- MEM_WB_Signal  out  1  1 = bubble; MEM/WB must clear its contents
- InstructionOut, MemToRegOut, RegWriteOut, WriteRegisterOut(32), ALUResultOut(32), DataMemoryOut(32)  out  registered bundle to MEM/WB
- AlignError  out  1  one-cycle pulse on a misaligned access
- BusError  out  1  sticky timeout flag; cleared only by Reset

Behaviour:
- Reset value: synchronous, active-high.
  - Every registered output is 0, except MEM_WB_Signal = 1.
  - MemReq = 0, state = IDLE, counter = 0, BusError = 0.
- Definitions:
  - memop = ValidIn & (MemReadIn | MemWriteIn)
  - mis = memop & (ALUResultIn[1:0] != 0)
- State machine has two states, IDLE and WAIT.
- IDLE:
  - !ValidIn: next edge loads a bubble (MEM_WB_Signal = 1, bundle outputs 0).
  - ValidIn & !memop: pass-through, latency 1. The bundle is registered with DataMemoryOut = 0 and MEM_WB_Signal = 0. Stall = 0.
  - mis: no request is issued. The next edge loads a bubble and AlignError = 1 for one cycle. Stall = 0, so the instruction is dropped.
  - memop & !mis: Stall = 1. The next edge performs all of the following:
    - latches address, write data, write type and the bundle
    - sets MemReq = 1, MemWe = MemWriteIn
    - clears the counter
    - loads a bubble
    - enters WAIT
- WAIT:
  - MemReq, MemWe, MemAddr and MemWData are held stable; the latched bundle is used and upstream inputs are ignored.
  - Stall = !MemAck.
  - MemAck = 1:
    - The next edge drops MemReq and registers the latched bundle with MEM_WB_Signal = 0.
    - DataMemoryOut = MemRData for loads, 0 for stores.
    - The state returns to IDLE.
    - Upstream advances on the same edge, because Stall = 0 that cycle.
  - No ack, counter = TIMEOUT_CYCLES-1:
    - Stall = 0.
    - The next edge drops MemReq, sets BusError, loads a bubble and returns to IDLE.
    - The instruction is discarded.
  - Otherwise: the counter increments and a bubble is loaded.
  - MemAck and timeout in the same cycle: the ack wins.
  - MemAck while in IDLE: ignored.
- Timing:
  - Memory-op latency = (cycles until MemAck) + 1 edge.
  - Fastest case, ack in the first WAIT cycle: result at MEM/WB input 2 edges after acceptance.
- Throughput: one non-memory instruction per cycle; no bubble between back-to-back non-memory ops.
- Reset mid-access: WAIT is abandoned and MemReq = 0 after the edge. The memory must tolerate a withdrawn request.

Test Plan:
1. Reset held 2 cycles, then released with ValidIn = 0 -> MEM_WB_Signal = 1, all bundle outputs 0, MemReq = 0, Stall = 0.
2. ADD (RegWrite = 1, WriteRegister = 5, ALUResult = 0x1234) -> after 1 edge: ALUResultOut = 0x1234, WriteRegisterOut = 5, MEM_WB_Signal = 0, Stall never asserted.
3. LW from addr 0x40, MemAck after 3 WAIT cycles with MemRData = 0xDEADBEEF:
   - Stall = 1 for 4 cycles.
   - MemAddr = 0x40 stable throughout.
   - MEM_WB_Signal = 1 during the wait.
   - Then DataMemoryOut = 0xDEADBEEF, MemToRegOut = 1.
4. SW to 0x44 of 0xA5A5A5A5, ack in first WAIT cycle -> MemWe = 1, MemWData = 0xA5A5A5A5; the following ADD issues with no extra bubble; DataMemoryOut = 0 for the store.
5. LW to 0x42 -> MemReq never asserted, AlignError pulses 1 cycle, bubble to MEM/WB, Stall = 0.
6. Two cases:
   - LW with MemAck held 0 and TIMEOUT_CYCLES = 4 -> MemReq drops after 4 WAIT cycles, BusError = 1 and stays 1, bubble out.
   - Reset asserted during WAIT -> MemReq = 0 after the edge and BusError cleared.
